// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Registers the decoded ID fields and resolves the ALU operands from the registered
// register-file data. A newer EX/MEM result takes priority over an older MEM/WB result.
// An optional load-use stall counter is included when IDEX_STALL_CNT_EN is defined.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  // Decode side
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [3:0]            id_alu_op,
  input  logic                  id_alu_src_pc,
  input  logic                  id_alu_src_imm,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  // Pipeline control
  input  logic                  ex_stall,
  input  logic                  flush,
  // Forwarding sources
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_result,
  // Execute side
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_opA,
  output logic [XLEN-1:0]       ex_opB,
  output logic [3:0]            ex_op,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
`ifdef IDEX_STALL_CNT_EN
  output logic [31:0]           stall_count,
`endif
  output logic                  load_use_stall
);

  logic                  valid_q;
  logic [XLEN-1:0]       pc_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic [XLEN-1:0]       rs2_data_q;
  logic [XLEN-1:0]       imm_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [3:0]            alu_op_q;
  logic                  src_pc_q;
  logic                  src_imm_q;
  logic                  reg_write_q;
  logic                  mem_read_q;
  logic                  mem_write_q;

  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;
  logic                  exmem_hit1;
  logic                  exmem_hit2;
  logic                  memwb_hit1;
  logic                  memwb_hit2;

  // Operand forwarding from the registered source indices; x0 never matches.
  always_comb begin
    exmem_hit1 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q);
    exmem_hit2 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q);
    memwb_hit1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q);
    memwb_hit2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q);

    fwd_rs1 = rs1_data_q;
    if (exmem_hit1) begin
      fwd_rs1 = exmem_result;
    end else if (memwb_hit1) begin
      fwd_rs1 = memwb_result;
    end

    fwd_rs2 = rs2_data_q;
    if (exmem_hit2) begin
      fwd_rs2 = exmem_result;
    end else if (memwb_hit2) begin
      fwd_rs2 = memwb_result;
    end
  end

  // Hazard detection and output operand selection.
  always_comb begin
    // Conservative: both source indices are compared even if one operand is unused.
    load_use_stall = valid_q && mem_read_q && id_valid && (rd_q != '0) &&
                     ((id_rs1 == rd_q) || (id_rs2 == rd_q));
    id_ready       = !ex_stall && !load_use_stall && !reset;

    ex_valid       = valid_q;
    ex_opA         = src_pc_q  ? pc_q  : fwd_rs1;
    ex_opB         = src_imm_q ? imm_q : fwd_rs2;
    ex_op          = alu_op_q;
    ex_store_data  = fwd_rs2;
    ex_pc          = pc_q;
    ex_rd          = rd_q;
    ex_reg_write   = reg_write_q && valid_q;
    ex_mem_read    = mem_read_q  && valid_q;
    ex_mem_write   = mem_write_q && valid_q;
  end

  // Pipeline register: reset > flush > hold > bubble > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      src_pc_q    <= 1'b0;
      src_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (ex_stall) begin
      // Capture forwarded data so it survives its producer leaving the pipe mid-hold.
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end else if (load_use_stall) begin
      valid_q <= 1'b0;
    end else begin
      valid_q     <= id_valid;
      pc_q        <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      alu_op_q    <= id_alu_op;
      src_pc_q    <= id_alu_src_pc;
      src_imm_q   <= id_alu_src_imm;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
    end
  end

`ifdef IDEX_STALL_CNT_EN
  // Saturating count of load-use stall cycles; flush cycles are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!flush && load_use_stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected EX-side results, and a
// monitor pops one entry for every cycle the stage presents a valid instruction.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_pc, id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
  logic        ex_stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] ex_opA, ex_opB, ex_store_data, ex_pc;
  logic [3:0]  ex_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src_pc(id_alu_src_pc), .id_alu_src_imm(id_alu_src_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_stall(ex_stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_op(ex_op),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
`ifdef IDEX_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [31:0] opa, opb, store;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic push(input int tag, input logic [31:0] opa, input logic [31:0] opb,
                      input logic [31:0] store, input logic [3:0] op, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.tag = tag; e.opa = opa; e.opb = opb; e.store = store; e.op = op; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] rs1d,
                       input logic [4:0] rs2, input logic [31:0] rs2d, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [3:0] op, input logic spc,
                       input logic simm, input logic rw, input logic mr, input logic mw);
    id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs1_data = rs1d; id_rs2 = rs2;
    id_rs2_data = rs2d; id_imm = imm; id_rd = rd; id_alu_op = op; id_alu_src_pc = spc;
    id_alu_src_imm = simm; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid EX cycle consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!done && ex_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got ex_valid=1 expected no instruction");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("opA[%0d]", e.tag), ex_opA, e.opa);
        chk($sformatf("opB[%0d]", e.tag), ex_opB, e.opb);
        chk($sformatf("store[%0d]", e.tag), ex_store_data, e.store);
        chk($sformatf("op[%0d]", e.tag), {28'd0, ex_op}, {28'd0, e.op});
        chk($sformatf("rd[%0d]", e.tag), {27'd0, ex_rd}, {27'd0, e.rd});
        chk($sformatf("ctl[%0d]", e.tag), {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
            {29'd0, e.rw, e.mr, e.mw});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    issue(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    no_fwd();
    #1;
    chk("ready_in_reset", {31'd0, id_ready}, 32'd0);
    tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("rst_op", {28'd0, ex_op}, 32'd0);
    reset = 1'b0;

    // Pass-through, then PC/imm operand selection
    issue(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 5'd3, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(1, 32'd5, 32'd7, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    chk("ready_idle", {31'd0, id_ready}, 32'd1);
    tick();
    issue(32'h200, 5'd1, 32'h9, 5'd2, 32'h66, 32'h44, 5'd8, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(2, 32'h200, 32'h44, 32'h66, 4'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    id_valid = 1'b0;
    tick();
    chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("bubble_rw", {31'd0, ex_reg_write}, 32'd0);

    // Forwarding priority
    issue(32'h300, 5'd3, 32'h1111, 5'd0, 32'h22, 32'h0, 5'd6, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(3, 32'hAAAA, 32'h22, 32'h22, 4'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    issue(32'h304, 5'd3, 32'h1111, 5'd0, 32'h22, 32'h0, 5'd6, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(4, 32'hBBBB, 32'h22, 32'h22, 4'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAAAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBBBB;
    tick();
    issue(32'h308, 5'd0, 32'h3333, 5'd0, 32'h44, 32'h0, 5'd6, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(5, 32'h3333, 32'h44, 32'h44, 4'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    exmem_reg_write = 1'b0;
    tick();
    id_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd0;
    memwb_reg_write = 1'b1; memwb_rd = 5'd0;
    tick();
    no_fwd();

    // Load-use: lw x4 then add x5,x4,x1
    issue(32'h400, 5'd1, 32'h1000, 5'd0, 32'h0, 32'h8, 5'd4, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push(6, 32'h1000, 32'h8, 32'h0, 4'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    issue(32'h404, 5'd4, 32'hDEAD, 5'd1, 32'h20, 32'h0, 5'd5, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(7, 32'h10, 32'h20, 32'h20, 4'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    chk("lu_ready", {31'd0, id_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("lu_clear", {31'd0, load_use_stall}, 32'd0);
    chk("lu_ready2", {31'd0, id_ready}, 32'd1);
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h10;
    tick();
    id_valid = 1'b0;
    tick();
    no_fwd();

    // Hold for 3 cycles while the rs2 producer retires after the first
    issue(32'h500, 5'd1, 32'h300, 5'd7, 32'h99, 32'h4, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push(8 + i, 32'h300, 32'h4, 32'h55, 4'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    push(12, 32'h7, 32'h8, 32'h8, 4'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    issue(32'h504, 5'd2, 32'h7, 5'd3, 32'h8, 32'h0, 5'd9, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ex_stall = 1'b1;
    exmem_reg_write = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h55;
    #1;
    chk("hold_ready", {31'd0, id_ready}, 32'd0);
    tick();
    exmem_reg_write = 1'b0;
    tick();
    tick();
    ex_stall = 1'b0;
    tick();
    id_valid = 1'b0;
    exmem_rd = 5'd0;
    tick();

    // Flush overrides hold; the arriving ID instruction is dropped too
    issue(32'h600, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 5'd10, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(13, 32'h11, 32'h22, 32'h22, 4'd5, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    issue(32'h604, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd11, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ex_stall = 1'b1; flush = 1'b1;
    tick();
    ex_stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);
    tick();
    chk("flush_drop", {31'd0, ex_valid}, 32'd0);

    // Reset in the middle of a hold
    issue(32'h700, 5'd1, 32'h77, 5'd2, 32'h88, 32'h0, 5'd12, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push(14, 32'h77, 32'h88, 32'h88, 4'd7, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    ex_stall = 1'b1; reset = 1'b1;
    #1;
    chk("rst_ready_a", {31'd0, id_ready}, 32'd0);
    tick();
    chk("rst_ready_b", {31'd0, id_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    tick();
    reset = 1'b0; ex_stall = 1'b0; id_valid = 1'b0;
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("post_rst_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("post_rst_op", {28'd0, ex_op}, 32'd0);
    chk("post_rst_rd", {27'd0, ex_rd}, 32'd0);
    tick();

`ifdef IDEX_STALL_CNT_EN
    chk("cnt_reset", stall_count, 32'd0);
    for (int k = 0; k < 3; k++) begin
      issue(32'h800, 5'd1, 32'h40, 5'd0, 32'h0, 32'h0, 5'd4, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      push(20 + 2 * k, 32'h40, 32'h0, 32'h0, 4'd0, 5'd4, 1'b1, 1'b1, 1'b0);
      tick();
      issue(32'h804, 5'd0, 32'h0, 5'd4, 32'h5, 32'h0, 5'd6, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      push(21 + 2 * k, 32'h0, 32'h5, 32'h5, 4'd0, 5'd6, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      id_valid = 1'b0;
      tick();
    end
    chk("cnt_three", stall_count, 32'd3);
    issue(32'h900, 5'd1, 32'h40, 5'd0, 32'h0, 32'h0, 5'd4, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push(30, 32'h40, 32'h0, 32'h0, 4'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    issue(32'h904, 5'd4, 32'h0, 5'd0, 32'h0, 32'h0, 5'd6, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("cnt_flush_stall", {31'd0, load_use_stall}, 32'd1);
    tick();
    flush = 1'b0; id_valid = 1'b0;
    chk("cnt_flush_hold", stall_count, 32'd3);
    tick();
`endif

    tick();
    chk("sb_drained", sb.size(), 32'd0);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-resolution stage of the 5-stage RV32I pipeline; sits directly upstream of the execute ALU and feeds its opA, opB and op inputs.
- Registers decoded fields from ID and applies EX/MEM and MEM/WB forwarding to the registered operands.
- Detects load-use hazards, inserting a bubble and back-pressuring ID.
- Supports downstream hold and branch flush.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID presents a valid instruction.
- id_ready  out  1  stage accepts the ID instruction this cycle.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  register indices.
- id_alu_op  in  4  ALU opcode, passed through unchanged.
- id_alu_src_pc  in  1  opA = PC instead of rs1.
- id_alu_src_imm  in  1  opB = imm instead of rs2.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- ex_stall  in  1  downstream hold; stage keeps its contents.
- flush  in  1  kill the instruction in this stage and the one arriving from ID.
- exmem_reg_write  in  1  EX/MEM forwarding source enable.
- exmem_rd  in  REG_ADDR_W  EX/MEM forwarding destination.
- exmem_result  in  XLEN  EX/MEM forwarding value.
- memwb_reg_write  in  1  MEM/WB forwarding source enable.
- memwb_rd  in  REG_ADDR_W  MEM/WB forwarding destination.
- memwb_result  in  XLEN  MEM/WB forwarding value.
- ex_valid  out  1  stage holds a live instruction.
- ex_opA, ex_opB  out  XLEN  resolved ALU operands.
- ex_op  out  4  ALU opcode.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.
- ex_pc  out  XLEN  registered PC.
- ex_rd  out  REG_ADDR_W  registered destination.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered controls, gated by ex_valid.
- load_use_stall  out  1  hazard detected this cycle.

Behaviour:
- Reset (clk edge with reset=1): all registers go to 0, so ex_valid=0, ex_op=0, ex_rd=0 and all controls 0. Reset mid-hold or mid-stall discards contents.
- Forwarding (combinational, from registered rs1/rs2):
  - EX/MEM wins over MEM/WB.
  - A source matches when its reg_write=1, its rd equals the registered rs index, and rd≠0.
  - x0 is never forwarded.
- ex_opA = registered PC if alu_src_pc, else forwarded rs1.
- ex_opB = registered imm if alu_src_imm, else forwarded rs2.
- ex_store_data = forwarded rs2 always.
- ex_reg_write, ex_mem_read, ex_mem_write = registered bit AND ex_valid.
- load_use_stall = ex_valid & ex_mem_read & id_valid & (ex_rd≠0) & ((id_rs1==ex_rd) | (id_rs2==ex_rd)). It is asserted even when the index belongs to an unused operand (conservative).
- id_ready = ~ex_stall & ~load_use_stall & ~reset.
- Per-edge priority:
  1. reset: clear everything.
  2. flush: ex_valid←0; ID instruction dropped. Flush overrides ex_stall.
  3. ex_stall: hold all fields. rs1_data/rs2_data registers reload with their forwarded values so forwarded data survives its producer retiring during the hold.
  4. load_use_stall: ex_valid←0 (bubble), other fields don't-care; ID holds because id_ready=0.
  5. Otherwise: load all ID fields; ex_valid←id_valid.
- Latency: ID fields appear on ex_* exactly 1 cycle after acceptance. Load-use costs exactly 1 bubble. On the next cycle the load has moved to MEM and MEM/WB forwarding resolves the operand.
- Bubble or invalid entry: ex_op and operands are don't-care, controls are forced 0.

Optional Feature:
- Macro IDEX_STALL_CNT_EN.
- Defined:
  - Adds output stall_count [31:0], reset to 0.
  - Increments by 1 on every edge where load_use_stall=1 and neither reset nor flush is active.
  - Saturates at 32'hFFFFFFFF (no wrap).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset: assert reset 2 cycles mid-traffic → ex_valid=0, ex_reg_write=0, ex_op=0 on the cycle after; id_ready=0 while reset=1.
2. Plain pass-through: id_rs1_data=5, id_rs2_data=7, alu_op=4'b0010, no forwarding match → next cycle ex_opA=5, ex_opB=7, ex_op=4'b0010, ex_valid=1.
3. Forward priority: registered rs1=3; exmem_rd=3, exmem_result=0xAAAA; memwb_rd=3, memwb_result=0xBBBB, both reg_write=1 → ex_opA=0xAAAA. With exmem_reg_write=0 → 0xBBBB. With rs1=0 and both rd=0 → register value kept.
4. Load-use: lw x4 in stage, ID presents add x5,x4,x1 → load_use_stall=1 and id_ready=0 for one cycle, bubble inserted (ex_valid=0). Add accepted next; with memwb_rd=4, memwb_result=0x10 → ex_opA=0x10.
5. Hold with retiring producer: ex_stall=1 for 3 cycles; exmem forwards 0x55 to rs2 in cycle 1 only → ex_store_data=0x55 in all 3 cycles and after release.
6. Flush during ex_stall → ex_valid=0 next cycle. With IDEX_STALL_CNT_EN defined, 3 load-use events → stall_count=3, and no increment on a flush cycle.
